// File: rtl/gpio_pkg.sv
// gpio_pkg: register offsets, STATUS bit positions and pulse FSM states
package gpio_pkg;
    localparam logic [2:0] OFF_DATA   = 3'd0;
    localparam logic [2:0] OFF_SET    = 3'd1;
    localparam logic [2:0] OFF_CLR    = 3'd2;
    localparam logic [2:0] OFF_TOG    = 3'd3;
    localparam logic [2:0] OFF_PULSE  = 3'd4;
    localparam logic [2:0] OFF_LEN    = 3'd5;
    localparam logic [2:0] OFF_STATUS = 3'd6;
    localparam int STAT_BUSY = 0;
    localparam int STAT_ERR  = 1;
    typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/gpio_out_port_pulse_timer.sv
// pulse_timer: prescaled down-counter that raises expire for one cycle after len ticks
module pulse_timer
    import gpio_pkg::*;
#(
    parameter int PRESCALE  = 50_000,
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 expire
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    state_t                state, state_n;
    logic [PW-1:0]         pre, pre_n;
    logic [LEN_WIDTH-1:0]  cnt, cnt_n;
    logic                  tick;
    assign tick = pre == PW'(PRESCALE - 1);
    assign busy = state == RUN;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            pre   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            pre   <= pre_n;
            cnt   <= cnt_n;
        end
    end
    // a zero length still runs one tick
    always_comb begin
        state_n = state;
        pre_n   = pre;
        cnt_n   = cnt;
        expire  = 1'b0;
        if (state == IDLE) begin
            if (start) begin
                state_n = RUN;
                pre_n   = '0;
                cnt_n   = len == '0 ? LEN_WIDTH'(1) : len;
            end
        end else begin
            pre_n = tick ? '0 : pre + 1'b1;
            if (tick) begin
                if (cnt > LEN_WIDTH'(1)) cnt_n = cnt - 1'b1;
                else begin
                    expire  = 1'b1;
                    state_n = IDLE;
                end
            end
        end
    end
endmodule

// File: rtl/gpio_out_port.sv
// gpio_out_port: bus-mapped GPIO output register with set/clear/toggle and one-shot pulse timer
module gpio_out_port
    import gpio_pkg::*;
#(
    parameter int                   OUT_WIDTH   = 9,
    parameter logic [31:0]          BASE_ADDR   = 32'h1001_0020,
    parameter logic [OUT_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                   PRESCALE    = 50_000,
    parameter int                   LEN_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we_i,
    input  logic                 re_i,
    input  logic [31:0]          addr_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          rdata_o,
    output logic                 rvalid_o,
    output logic                 sel_o,
    output logic [OUT_WIDTH-1:0] gpio_o,
    output logic                 pulse_busy_o
);
    logic [2:0]           off;
    logic                 wr, rd, start, expire, err, err_set, err_clr;
    logic [OUT_WIDTH-1:0] d, mask, g_exp, g_n;
    logic [LEN_WIDTH-1:0] len;
    logic [31:0]          rmux;
    assign sel_o   = addr_i[31:5] == BASE_ADDR[31:5] && addr_i[1:0] == 2'b00;
    assign off     = addr_i[4:2];
    assign wr      = we_i && sel_o;
    assign rd      = re_i && sel_o;
    assign d       = wdata_i[OUT_WIDTH-1:0];
    assign start   = wr && off == OFF_PULSE && !pulse_busy_o && |d;
    assign err_set = wr && off == OFF_PULSE && pulse_busy_o;
    assign err_clr = wr && off == OFF_STATUS && wdata_i[STAT_ERR];
    // expiry clears first so a coinciding CPU write wins per bit
    assign g_exp = expire ? gpio_o & ~mask : gpio_o;
    assign g_n   = !wr                ? g_exp :
                   off == OFF_DATA    ? d :
                   off == OFF_SET     ? g_exp | d :
                   off == OFF_CLR     ? g_exp & ~d :
                   off == OFF_TOG     ? g_exp ^ d :
                   start              ? g_exp | d : g_exp;
    assign rmux  = off == OFF_DATA    ? 32'(gpio_o) :
                   off == OFF_PULSE   ? 32'(mask) :
                   off == OFF_LEN     ? 32'(len) :
                   off == OFF_STATUS  ? {30'd0, err, pulse_busy_o} : 32'd0;
    pulse_timer #(.PRESCALE(PRESCALE), .LEN_WIDTH(LEN_WIDTH)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .len    (len),
        .busy   (pulse_busy_o),
        .expire (expire)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpio_o   <= RESET_VALUE;
            mask     <= '0;
            len      <= LEN_WIDTH'(1);
            err      <= 1'b0;
            rdata_o  <= '0;
            rvalid_o <= 1'b0;
        end else begin
            gpio_o   <= g_n;
            mask     <= start ? d : expire ? '0 : mask;
            len      <= wr && off == OFF_LEN ? wdata_i[LEN_WIDTH-1:0] : len;
            err      <= err_set ? 1'b1 : err_clr ? 1'b0 : err;
            rdata_o  <= rd ? rmux : rdata_o;
            rvalid_o <= rd;
        end
    end
endmodule

// File: tb/tb_gpio_out_port.sv
// tb_gpio_out_port: randomized bus traffic checked against a cycle-count reference model
module tb_gpio_out_port;
    localparam int          OW    = 9;
    localparam logic [31:0] BASE  = 32'h1001_0020;
    localparam logic [8:0]  RV    = 9'h0AA;
    localparam int          PS    = 4;
    logic        clk = 0, rst = 0, we_i = 0, re_i = 0, sel_o, rvalid_o, pulse_busy_o;
    logic [31:0] addr_i = 0, wdata_i = 0, rdata_o;
    logic [OW-1:0] gpio_o;
    int n_chk = 0, n_fail = 0;
    int cyc = 0, m_end = 0;
    logic [OW-1:0] m_g, m_mask;
    logic [15:0]   m_len;
    logic          m_err, m_run, m_rvalid;
    logic [31:0]   m_rdata;

    gpio_out_port #(.OUT_WIDTH(OW), .BASE_ADDR(BASE), .RESET_VALUE(RV), .PRESCALE(PS), .LEN_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .we_i(we_i), .re_i(re_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .rdata_o(rdata_o), .rvalid_o(rvalid_o), .sel_o(sel_o), .gpio_o(gpio_o), .pulse_busy_o(pulse_busy_o)
    );
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_g = RV; m_mask = 0; m_len = 1; m_err = 0; m_run = 0; m_rvalid = 0; m_rdata = 0;
    endtask

    function automatic logic [31:0] reg_val(input logic [2:0] o);
        case (o)
            3'd0: return 32'(m_g);
            3'd4: return 32'(m_mask);
            3'd5: return 32'(m_len);
            3'd6: return {30'd0, m_err, m_run};
            default: return 0;
        endcase
    endfunction

    task automatic check_outs();
        check("gpio", 32'(gpio_o), 32'(m_g));
        check("busy", 32'(pulse_busy_o), 32'(m_run));
        check("rvalid", 32'(rvalid_o), 32'(m_rvalid));
        check("rdata", rdata_o, m_rdata);
    endtask

    // one bus cycle: drive, check decode, clock, advance model, check outputs
    task automatic bus(input logic w, input logic r, input logic [31:0] a, input logic [31:0] dat);
        logic hit, run_pre;
        logic [2:0] o;
        logic [OW-1:0] dv;
        hit = a[31:5] == BASE[31:5] && a[1:0] == 0;
        o = a[4:2];
        dv = dat[OW-1:0];
        we_i = w; re_i = r; addr_i = a; wdata_i = dat;
        #1 check("sel", 32'(sel_o), 32'(hit));
        @(posedge clk);
        cyc++;
        run_pre = m_run;
        m_rvalid = r && hit;
        if (r && hit) m_rdata = reg_val(o);
        if (m_run && cyc == m_end) begin
            m_g &= ~m_mask; m_mask = 0; m_run = 0;
        end
        if (w && hit) case (o)
            3'd0: m_g = dv;
            3'd1: m_g |= dv;
            3'd2: m_g &= ~dv;
            3'd3: m_g ^= dv;
            3'd4: if (run_pre) m_err = 1;
                  else if (dv != 0) begin
                      m_g |= dv; m_mask = dv; m_run = 1;
                      m_end = cyc + (m_len == 0 ? 1 : int'(m_len)) * PS;
                  end
            3'd5: m_len = dat[15:0];
            3'd6: if (dat[1]) m_err = 0;
            default: ;
        endcase
        #1 check_outs();
    endtask

    task automatic wr(input int o, input logic [31:0] dat); bus(1, 0, BASE + 32'(o * 4), dat); endtask
    task automatic rd(input int o); bus(0, 1, BASE + 32'(o * 4), 0); endtask
    task automatic idle(input int n); for (int i = 0; i < n; i++) bus(0, 0, 0, 0); endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_outs();
        @(negedge clk) rst = 1;
        rd(5);
        wr(0, 32'h1FF); wr(2, 32'h00F); wr(3, 32'h101); wr(1, 32'h002);
        check("seq_gpio", 32'(gpio_o), 32'h0F3);
        rd(0);
        check("rd_data", rdata_o, 32'h0F3);
        wr(0, 0); wr(5, 3); wr(4, 32'h010);
        idle(5);
        wr(4, 32'h020);
        rd(6);
        check("status_run", rdata_o, 32'h3);
        idle(12);
        wr(6, 2); rd(6);
        check("status_clr", rdata_o, 32'h0);
        wr(5, 1); wr(4, 32'h010); idle(3); wr(1, 32'h010);
        check("expiry_vs_set", 32'(gpio_o[4]), 1);
        bus(1, 1, BASE + 32'h21, 32'h1FF);
        bus(1, 1, 32'h1001_0040, 32'h1FF);
        bus(1, 1, BASE + 32'h1, 32'h1FF);
        wr(5, 3); wr(4, 32'h003); idle(2);
        #1 rst = 0;
        #1 model_reset();
        check_outs();
        #1 rst = 1;
        wr(4, 32'h100); idle(14);
        for (int i = 0; i < 1500; i++) begin
            int k;
            logic [31:0] a, dat;
            k = $urandom_range(0, 9);
            a = BASE + 32'($urandom_range(0, 7) * 4);
            if (k == 0) a = BASE + 32'($urandom_range(1, 3));
            if (k == 1) a = $urandom;
            dat = $urandom;
            if (a[4:2] == 3'd5) dat &= 32'h7;
            if (k == 2) bus(1, 0, BASE + 32'h10, dat);
            else bus(1'($urandom), 1'($urandom), a, dat);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/gpio_out_port.md
Name: gpio_out_port

Overview:
- Memory-mapped GPIO output peripheral on the multicycle MIPS core's data bus. It is the write/drive counterpart of the core's GPIO input path.
- The core stores to its register window to drive board LEDs. Supports direct write plus set/clear/toggle, and a hardware one-shot pulse timer that auto-clears selected bits.
- Reads return register contents with fixed 1-cycle latency.

Parameters:
- OUT_WIDTH, 9: number of driven output bits (LEDR[8:0]).
- BASE_ADDR, 32'h1001_0020: register window base, 32-byte aligned.
- RESET_VALUE, 0: gpio_o value after reset.
- PRESCALE, 50_000: clk cycles per pulse-timer tick; must be >= 1.
- LEN_WIDTH, 16: width of the PULSE_LEN register.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- we_i  in  1  bus write strobe, one cycle per access.
- re_i  in  1  bus read strobe, one cycle per access.
- addr_i  in  32  byte address.
- wdata_i  in  32  write data.
- rdata_o  out  32  read data, registered.
- rvalid_o  out  1  one-cycle pulse; rdata_o valid.
- sel_o  out  1  combinational address hit.
- gpio_o  out  OUT_WIDTH  registered output pins.
- pulse_busy_o  out  1  pulse FSM in RUN.

Behaviour:
- Address hit: addr_i[31:5] == BASE_ADDR[31:5] and addr_i[1:0] == 0. Offset is addr_i[4:2]. Misaligned or miss: access ignored, sel_o = 0.
- Register map:
  - 0 DATA: RW.
  - 1 SET: W, gpio |= d.
  - 2 CLR: W, gpio &= ~d.
  - 3 TOG: W, gpio ^= d.
  - 4 PULSE: W starts a pulse on mask d; reads return the active mask.
  - 5 PULSE_LEN: RW, ticks.
  - 6 STATUS: bit0 busy (RO); bit1 err (sticky, write 1 to clear).
  - 7: reads 0, writes ignored.
- Write data bits >= OUT_WIDTH are ignored. Read bits above register width return 0.
- Reset (rst = 0, async):
  - gpio_o = RESET_VALUE; rdata_o = 0; rvalid_o = 0.
  - PULSE_LEN = 1; pulse mask = 0; err = 0; FSM = IDLE; prescaler and counter = 0.
- Write timing: gpio_o reflects a write on the edge where we_i & hit, i.e. visible the next cycle.
- Read timing:
  - re_i & hit → rdata_o and rvalid_o = 1 on the next edge. rvalid_o is 0 otherwise; rdata_o holds its last value.
  - we_i and re_i in the same cycle: the write executes and the read returns the pre-write value.
- Pulse FSM, IDLE → RUN: PULSE write with nonzero mask m (masked to OUT_WIDTH) in IDLE.
  - gpio |= m; mask = m.
  - cnt = max(PULSE_LEN, 1); prescaler = 0.
  - A zero mask is a no-op.
- RUN:
  - Prescaler counts 0..PRESCALE-1; a tick occurs on wrap.
  - On tick with cnt > 1: cnt--.
  - On tick with cnt == 1: gpio &= ~mask, mask = 0, → IDLE.
  - Pulse width is exactly PULSE_LEN × PRESCALE cycles from the cycle after the write.
- PULSE write during RUN: ignored; err = 1. The running pulse is unaffected.
- PULSE_LEN write during RUN takes effect on the next pulse only.
- Simultaneous expiry and CPU DATA/SET/CLR/TOG write: expiry clear is applied first, then the CPU op on the result, so CPU wins per bit.
- CPU CLR/TOG of pulse bits during RUN is allowed. Expiry still clears the masked bits.
- Simultaneous err-set and STATUS write-1-clear: set wins.
- Reset mid-pulse: immediate return to IDLE with reset values.

Decomposition:
- gpio_pkg: register offsets (OFF_DATA..OFF_STATUS), STATUS bit indices, FSM state enum {IDLE, RUN}.
- Sub-module pulse_timer: prescaler, down-counter, start/expire handshake.
  - Inputs: start, len.
  - Outputs: busy, expire (one-cycle).

Test Plan:
- Reset with RESET_VALUE = 9'h0AA → gpio_o = 0x0AA, rvalid_o = 0, pulse_busy_o = 0; read PULSE_LEN → 1.
- Write DATA = 0x1FF, then CLR 0x00F, TOG 0x101, SET 0x002 → gpio_o = 0x1F0, then 0x0F1, then 0x0F3, each one cycle after its write; read DATA → rdata_o = 0x0F3 with rvalid_o one cycle after re_i.
- PRESCALE = 4, PULSE_LEN = 3, write PULSE = 0x010 with gpio = 0 → gpio_o[4] high for exactly 12 cycles, pulse_busy_o high for the same window, then 0.
- During RUN write PULSE = 0x020 → ignored, STATUS = 0x3; write STATUS = 0x2 after expiry → STATUS = 0x0.
- Expiry cycle coincides with SET 0x010 → gpio_o[4] stays 1. Write to addr BASE_ADDR + 0x21 or 0x1001_0040 → no change, sel_o = 0, no rvalid_o.
- Assert rst mid-pulse → gpio_o = RESET_VALUE immediately (async), busy = 0; after release, a new PULSE starts normally.
